// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: ALU commands, shift types,
// forwarding selects, status bit positions and the EXE/MEM register layout.
package exe_stage_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001
    } alu_cmd_e;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_type_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic              wb_en;
        logic              mem_read;
        logic              mem_write;
        logic [3:0]        dest;
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] val_rm;
    } exe_mem_t;

    // A shift by 32 yields zero, so an amount of 0 returns the value unchanged.
    function automatic logic [DATA_W-1:0] ror32(input logic [DATA_W-1:0] val,
                                                input logic [4:0]        amt);
        return (val >> amt) | (val << (6'd32 - {1'b0, amt}));
    endfunction

endpackage

// File: rtl/exe_stage_val2_generator.sv
// Second ALU operand: memory offset, rotated 8-bit immediate or shifted Rm.
module exe_stage_val2_generator
    import exe_stage_pkg::*;
(
    input  logic              mem_op,
    input  logic              imm,
    input  logic [11:0]       shift_operand,
    input  logic [DATA_W-1:0] rm_val,
    output logic [DATA_W-1:0] val2
);

    logic [4:0] shift_amt;

    assign shift_amt = shift_operand[11:7];

    // Operand 2 source in priority order: memory offset, immediate, register shift
    always_comb begin
        val2 = rm_val;
        if (mem_op) begin
            val2 = {{20{shift_operand[11]}}, shift_operand};
        end else if (imm) begin
            val2 = ror32({24'd0, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
        end else begin
            case (shift_operand[6:5])
                SHIFT_LSL: val2 = rm_val << shift_amt;
                SHIFT_LSR: val2 = rm_val >> shift_amt;
                SHIFT_ASR: val2 = $unsigned($signed(rm_val) >>> shift_amt);
                SHIFT_ROR: val2 = ror32(rm_val, shift_amt);
                default:   val2 = rm_val;
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: forwarding, operand 2 generation, ALU, branch target,
// NZCV status register and the EXE/MEM pipeline register.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             wb_en_in,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic             imm_in,
    input  logic             branch_in,
    input  logic             s_in,
    input  logic [3:0]       exe_cmd_in,
    input  logic [3:0]       dest_in,
    input  logic [11:0]      shift_operand_in,
    input  logic [23:0]      signed_imm_in,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] val_rn_in,
    input  logic [WIDTH-1:0] val_rm_in,
    input  logic [1:0]       sel_src1,
    input  logic [1:0]       sel_src2,
    input  logic [WIDTH-1:0] mem_fwd_val,
    input  logic [WIDTH-1:0] wb_fwd_val,
    output logic             branch_taken,
    output logic [WIDTH-1:0] branch_address,
    output logic [3:0]       status_out,
    output logic             wb_en_mem,
    output logic             mem_read_mem,
    output logic             mem_write_mem,
    output logic [3:0]       dest_mem,
    output logic [WIDTH-1:0] alu_res_mem,
    output logic [WIDTH-1:0] val_rm_mem
);

    logic [WIDTH-1:0] op1, rm_f, val2, alu_res;
    logic [WIDTH:0]   add_sum, sub_diff;
    logic             add_cin, sub_bin, carry, ovf;
    logic [3:0]       flags, status_d, status_q;
    exe_mem_t         exe_mem_d, exe_mem_q;

    // Forwarding muxes; the unused select code falls back to the register file
    always_comb begin
        case (sel_src1)
            FWD_MEM: op1 = mem_fwd_val;
            FWD_WB:  op1 = wb_fwd_val;
            default: op1 = val_rn_in;
        endcase
        case (sel_src2)
            FWD_MEM: rm_f = mem_fwd_val;
            FWD_WB:  rm_f = wb_fwd_val;
            default: rm_f = val_rm_in;
        endcase
    end

    exe_stage_val2_generator u_val2_generator (
        .mem_op        (mem_read_in | mem_write_in),
        .imm           (imm_in),
        .shift_operand (shift_operand_in),
        .rm_val        (rm_f),
        .val2          (val2)
    );

    assign add_cin  = (exe_cmd_in == CMD_ADC) & status_q[FLAG_C];
    assign sub_bin  = (exe_cmd_in == CMD_SBC) & ~status_q[FLAG_C];
    assign add_sum  = {1'b0, op1} + {1'b0, val2} + {{WIDTH{1'b0}}, add_cin};
    assign sub_diff = {1'b0, op1} - {1'b0, val2} - {{WIDTH{1'b0}}, sub_bin};

    // ALU; logical and move commands carry C and V through unchanged
    always_comb begin
        alu_res = {WIDTH{1'b0}};
        carry   = status_q[FLAG_C];
        ovf     = status_q[FLAG_V];
        case (exe_cmd_in)
            CMD_MOV: alu_res = val2;
            CMD_MVN: alu_res = ~val2;
            CMD_ADD, CMD_ADC: begin
                alu_res = add_sum[WIDTH-1:0];
                carry   = add_sum[WIDTH];
                ovf     = (op1[WIDTH-1] == val2[WIDTH-1]) & (add_sum[WIDTH-1] != op1[WIDTH-1]);
            end
            CMD_SUB, CMD_SBC: begin
                alu_res = sub_diff[WIDTH-1:0];
                carry   = ~sub_diff[WIDTH];
                ovf     = (op1[WIDTH-1] != val2[WIDTH-1]) & (sub_diff[WIDTH-1] != op1[WIDTH-1]);
            end
            CMD_AND: alu_res = op1 & val2;
            CMD_ORR: alu_res = op1 | val2;
            CMD_EOR: alu_res = op1 ^ val2;
            default: alu_res = {WIDTH{1'b0}};
        endcase
        flags         = 4'b0000;
        flags[FLAG_N] = alu_res[WIDTH-1];
        flags[FLAG_Z] = (alu_res == {WIDTH{1'b0}});
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end

    assign branch_taken   = branch_in;
    assign branch_address = pc_in + {{(WIDTH-26){signed_imm_in[23]}}, signed_imm_in, 2'b00};

    // Next state: freeze holds both registers so a stalled ADC/SBC keeps its carry-in
    always_comb begin
        if (freeze) begin
            exe_mem_d = exe_mem_q;
            status_d  = status_q;
        end else begin
            exe_mem_d.wb_en     = wb_en_in;
            exe_mem_d.mem_read  = mem_read_in;
            exe_mem_d.mem_write = mem_write_in;
            exe_mem_d.dest      = dest_in;
            exe_mem_d.alu_res   = alu_res;
            exe_mem_d.val_rm    = rm_f;
            status_d            = s_in ? flags : status_q;
        end
    end

    // State registers; reset overrides freeze
    always_ff @(posedge clk) begin
        if (rst) begin
            exe_mem_q <= '0;
            status_q  <= 4'b0000;
        end else begin
            exe_mem_q <= exe_mem_d;
            status_q  <= status_d;
        end
    end

    assign status_out    = status_q;
    assign wb_en_mem     = exe_mem_q.wb_en;
    assign mem_read_mem  = exe_mem_q.mem_read;
    assign mem_write_mem = exe_mem_q.mem_write;
    assign dest_mem      = exe_mem_q.dest;
    assign alu_res_mem   = exe_mem_q.alu_res;
    assign val_rm_mem    = exe_mem_q.val_rm;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed vector table, freeze/reset sequence and
// random stimulus compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst, freeze, wb_en_in, mem_read_in, mem_write_in, imm_in, branch_in, s_in;
    logic [3:0]  exe_cmd_in, dest_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in, mem_fwd_val, wb_fwd_val;
    logic [1:0]  sel_src1, sel_src2;
    logic        branch_taken, wb_en_mem, mem_read_mem, mem_write_mem;
    logic [31:0] branch_address, alu_res_mem, val_rm_mem;
    logic [3:0]  status_out, dest_mem;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [3:0]  m_status;
    logic [6:0]  m_ctl;
    logic [31:0] m_res, m_rm;

    typedef struct {
        logic [3:0]  cmd;
        logic        imm;
        logic        mem_wr;
        logic        s;
        logic [11:0] so;
        logic [31:0] rn, rm;
        logic [1:0]  s1, s2;
        logic [31:0] mfwd, wfwd, pc;
        logic [23:0] simm;
        logic        br;
        logic [31:0] exp_res;
        logic [3:0]  exp_st;
        logic [31:0] exp_rm, exp_ba;
    } vec_t;

    vec_t vecs[$];

    exe_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .wb_en_in(wb_en_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .imm_in(imm_in), .branch_in(branch_in), .s_in(s_in),
        .exe_cmd_in(exe_cmd_in), .dest_in(dest_in),
        .shift_operand_in(shift_operand_in), .signed_imm_in(signed_imm_in),
        .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
        .sel_src1(sel_src1), .sel_src2(sel_src2),
        .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
        .branch_taken(branch_taken), .branch_address(branch_address),
        .status_out(status_out), .wb_en_mem(wb_en_mem), .mem_read_mem(mem_read_mem),
        .mem_write_mem(mem_write_mem), .dest_mem(dest_mem),
        .alu_res_mem(alu_res_mem), .val_rm_mem(val_rm_mem)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        rst = 1'b0; freeze = 1'b0; wb_en_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        imm_in = 1'b0; branch_in = 1'b0; s_in = 1'b0; exe_cmd_in = 4'd0; dest_in = 4'd0;
        shift_operand_in = 12'd0; signed_imm_in = 24'd0; pc_in = 32'd0;
        val_rn_in = 32'd0; val_rm_in = 32'd0; sel_src1 = 2'd0; sel_src2 = 2'd0;
        mem_fwd_val = 32'd0; wb_fwd_val = 32'd0;
    endtask

    task automatic add_vec(input logic [3:0] cmd, input logic imm, input logic mem_wr,
                           input logic s, input logic [11:0] so, input logic [31:0] rn,
                           input logic [31:0] rm, input logic [1:0] s1, input logic [1:0] s2,
                           input logic [31:0] mfwd, input logic [31:0] wfwd,
                           input logic [31:0] pc, input logic [23:0] simm, input logic br,
                           input logic [31:0] exp_res, input logic [3:0] exp_st,
                           input logic [31:0] exp_rm, input logic [31:0] exp_ba);
        vec_t v;
        v.cmd = cmd; v.imm = imm; v.mem_wr = mem_wr; v.s = s; v.so = so; v.rn = rn; v.rm = rm;
        v.s1 = s1; v.s2 = s2; v.mfwd = mfwd; v.wfwd = wfwd; v.pc = pc; v.simm = simm; v.br = br;
        v.exp_res = exp_res; v.exp_st = exp_st; v.exp_rm = exp_rm; v.exp_ba = exp_ba;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] reg_val);
        if (sel == 2'd1) return mem_fwd_val;
        if (sel == 2'd2) return wb_fwd_val;
        return reg_val;
    endfunction

    // Operand 2 built bit-by-bit with one-position moves
    function automatic logic [31:0] m_val2(input logic memop, input logic imm,
                                           input logic [11:0] so, input logic [31:0] x);
        logic [31:0] y;
        int rot, n;
        if (memop) return {{20{so[11]}}, so};
        if (imm) begin
            y = {24'd0, so[7:0]};
            rot = 2 * int'(so[11:8]);
            for (int i = 0; i < rot; i++) y = {y[0], y[31:1]};
            return y;
        end
        y = x;
        n = int'(so[11:7]);
        for (int i = 0; i < n; i++) begin
            case (so[6:5])
                2'd0:    y = {y[30:0], 1'b0};
                2'd1:    y = {1'b0, y[31:1]};
                2'd2:    y = {y[31], y[31:1]};
                default: y = {y[0], y[31:1]};
            endcase
        end
        return y;
    endfunction

    // Returns {N,Z,C,V, result} using 64-bit integer arithmetic
    function automatic logic [35:0] m_alu(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] st);
        longint ua, ub, us, sa, sb, ss, k;
        logic [31:0] r;
        logic c, v;
        ua = longint'(a); ub = longint'(b);
        sa = longint'($signed(a)); sb = longint'($signed(b));
        c = st[1]; v = st[0]; r = 32'd0;
        case (cmd)
            4'b0001: r = b;
            4'b1001: r = ~b;
            4'b0010, 4'b0011: begin
                k  = (cmd == 4'b0011) ? longint'(st[1]) : 64'sd0;
                us = ua + ub + k;
                r  = us[31:0];
                c  = (us > 64'sd4294967295);
                ss = sa + sb + k;
                v  = (ss != longint'($signed(r)));
            end
            4'b0100, 4'b0101: begin
                k  = (cmd == 4'b0101) ? longint'(!st[1]) : 64'sd0;
                us = ua - ub - k;
                r  = us[31:0];
                c  = (ua >= ub + k);
                ss = sa - sb - k;
                v  = (ss != longint'($signed(r)));
            end
            4'b0110: r = a & b;
            4'b0111: r = a | b;
            4'b1000: r = a ^ b;
            default: r = 32'd0;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    task automatic model_edge();
        logic [31:0] a, rmf, b;
        logic [35:0] r;
        if (rst) begin
            m_status = 4'd0; m_ctl = 7'd0; m_res = 32'd0; m_rm = 32'd0;
        end else if (!freeze) begin
            a   = m_fwd(sel_src1, val_rn_in);
            rmf = m_fwd(sel_src2, val_rm_in);
            b   = m_val2(mem_read_in | mem_write_in, imm_in, shift_operand_in, rmf);
            r   = m_alu(exe_cmd_in, a, b, m_status);
            if (s_in) m_status = r[35:32];
            m_res = r[31:0];
            m_rm  = rmf;
            m_ctl = {wb_en_in, mem_read_in, mem_write_in, dest_in};
        end
    endtask

    task automatic check_regs(input string tag, input logic [31:0] e_res, input logic [3:0] e_st,
                              input logic [31:0] e_rm, input logic [6:0] e_ctl);
        check({tag, "_res"},    alu_res_mem, e_res);
        check({tag, "_status"}, {28'd0, status_out}, {28'd0, e_st});
        check({tag, "_rm"},     val_rm_mem, e_rm);
        check({tag, "_ctl"},    {25'd0, wb_en_mem, mem_read_mem, mem_write_mem, dest_mem},
                                {25'd0, e_ctl});
    endtask

    initial begin
        logic [31:0] exp_ba;
        clear_inputs();

        // Reset state
        rst = 1'b1; wb_en_in = 1'b1; dest_in = 4'd5; val_rn_in = 32'd9; s_in = 1'b1;
        exe_cmd_in = 4'b0001; imm_in = 1'b1; shift_operand_in = 12'h0FF;
        @(posedge clk); #1;
        check_regs("reset", 32'd0, 4'b0000, 32'd0, 7'd0);

        // cmd imm mw s so rn rm s1 s2 mfwd wfwd pc simm br | res st rm ba
        add_vec(4'b0010,1,0,1,12'h001,32'd5,32'd0,0,0,0,0,0,0,0, 32'd6,4'b0000,32'd0,32'd0);
        add_vec(4'b0100,0,0,1,12'h000,32'd3,32'd3,0,0,0,0,0,0,0, 32'd0,4'b0110,32'd3,32'd0);
        add_vec(4'b0011,0,0,1,12'h000,32'hFFFFFFFF,32'd0,0,0,0,0,0,0,0, 32'd0,4'b0110,32'd0,32'd0);
        add_vec(4'b0001,1,0,1,12'h001,32'd0,32'd0,0,0,0,0,0,0,0, 32'd1,4'b0010,32'd0,32'd0);
        add_vec(4'b0001,1,0,1,12'h4FF,32'd0,32'd0,0,0,0,0,0,0,0, 32'hFF000000,4'b1010,32'd0,32'd0);
        add_vec(4'b0001,0,0,0,12'h240,32'd0,32'h80000000,0,0,0,0,0,0,0,
                32'hF8000000,4'b1010,32'h80000000,32'd0);
        add_vec(4'b0010,1,0,0,12'h001,32'd0,32'd0,2'b01,0,32'd7,0,0,0,0, 32'd8,4'b1010,32'd0,32'd0);
        add_vec(4'b0000,0,0,0,12'h000,32'd0,32'd0,0,0,0,0,32'h100,24'hFFFFFE,1,
                32'd0,4'b1010,32'd0,32'hF8);
        add_vec(4'b0010,0,1,0,12'hFFC,32'h1000,32'd5,0,2'b10,0,32'hDEADBEEF,0,0,0,
                32'hFFC,4'b1010,32'hDEADBEEF,32'd0);
        add_vec(4'b0101,1,0,1,12'h001,32'h10,32'd0,0,0,0,0,0,0,0, 32'hF,4'b0010,32'd0,32'd0);
        add_vec(4'b0100,1,0,1,12'h001,32'd0,32'd0,0,0,0,0,0,0,0, 32'hFFFFFFFF,4'b1000,32'd0,32'd0);
        add_vec(4'b0101,1,0,1,12'h001,32'd5,32'd0,0,0,0,0,0,0,0, 32'd3,4'b0010,32'd0,32'd0);
        add_vec(4'b0010,1,0,1,12'h001,32'h7FFFFFFF,32'd0,0,0,0,0,0,0,0,
                32'h80000000,4'b1001,32'd0,32'd0);
        add_vec(4'b1111,1,0,1,12'h001,32'd9,32'd0,0,0,0,0,0,0,0, 32'd0,4'b0101,32'd0,32'd0);
        add_vec(4'b0001,0,0,0,12'h220,32'd0,32'hF0,0,0,0,0,32'hFFFFFFFC,24'd2,1,
                32'hF,4'b0101,32'hF0,32'h4);
        add_vec(4'b0001,0,0,0,12'h460,32'd0,32'hAB,0,0,0,0,0,0,0,
                32'hAB000000,4'b0101,32'hAB,32'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            clear_inputs();
            exe_cmd_in = vecs[i].cmd; imm_in = vecs[i].imm; mem_write_in = vecs[i].mem_wr;
            s_in = vecs[i].s; shift_operand_in = vecs[i].so; val_rn_in = vecs[i].rn;
            val_rm_in = vecs[i].rm; sel_src1 = vecs[i].s1; sel_src2 = vecs[i].s2;
            mem_fwd_val = vecs[i].mfwd; wb_fwd_val = vecs[i].wfwd; pc_in = vecs[i].pc;
            signed_imm_in = vecs[i].simm; branch_in = vecs[i].br;
            #1;
            check($sformatf("tbl%0d_baddr", i), branch_address, vecs[i].exp_ba);
            check($sformatf("tbl%0d_taken", i), {31'd0, branch_taken}, {31'd0, vecs[i].br});
            @(posedge clk); #1;
            check($sformatf("tbl%0d_res", i), alu_res_mem, vecs[i].exp_res);
            check($sformatf("tbl%0d_status", i), {28'd0, status_out}, {28'd0, vecs[i].exp_st});
            check($sformatf("tbl%0d_rm", i), val_rm_mem, vecs[i].exp_rm);
        end

        // Freeze holds, reset wins over freeze, then release
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        clear_inputs();
        exe_cmd_in = 4'b0010; imm_in = 1'b1; shift_operand_in = 12'h001; val_rn_in = 32'd5;
        s_in = 1'b1; wb_en_in = 1'b1; dest_in = 4'd3;
        @(posedge clk); #1;
        check_regs("frz_setup", 32'd6, 4'b0000, 32'd0, 7'b1000011);
        @(negedge clk);
        clear_inputs();
        freeze = 1'b1; exe_cmd_in = 4'b0100; val_rn_in = 32'd3; val_rm_in = 32'd3;
        s_in = 1'b1; dest_in = 4'd9; mem_read_in = 1'b1;
        @(posedge clk); #1;
        check_regs("frz_c1", 32'd6, 4'b0000, 32'd0, 7'b1000011);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_regs("frz_rst", 32'd0, 4'b0000, 32'd0, 7'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_regs("frz_c3", 32'd0, 4'b0000, 32'd0, 7'd0);
        @(negedge clk);
        freeze = 1'b0; mem_read_in = 1'b0;
        @(posedge clk); #1;
        check_regs("frz_rel", 32'd0, 4'b0110, 32'd3, 7'b0001001);

        // Random stimulus against the model, starting from reset
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        m_status = 4'd0; m_ctl = 7'd0; m_res = 32'd0; m_rm = 32'd0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            rst              = ($urandom_range(0, 39) == 0);
            freeze           = ($urandom_range(0, 4) == 0);
            wb_en_in         = 1'($urandom);
            mem_read_in      = ($urandom_range(0, 5) == 0);
            mem_write_in     = ($urandom_range(0, 5) == 0);
            imm_in           = 1'($urandom);
            branch_in        = 1'($urandom);
            s_in             = 1'($urandom);
            exe_cmd_in       = 4'($urandom);
            dest_in          = 4'($urandom);
            shift_operand_in = 12'($urandom);
            signed_imm_in    = 24'($urandom);
            pc_in            = $urandom;
            val_rn_in        = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            val_rm_in        = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
            sel_src1         = 2'($urandom);
            sel_src2         = 2'($urandom);
            mem_fwd_val      = $urandom;
            wb_fwd_val       = $urandom;
            #1;
            exp_ba = pc_in + 32'(int'($signed(signed_imm_in)) * 4);
            check($sformatf("rnd%0d_baddr", k), branch_address, exp_ba);
            check($sformatf("rnd%0d_taken", k), {31'd0, branch_taken}, {31'd0, branch_in});
            model_edge();
            @(posedge clk); #1;
            check_regs($sformatf("rnd%0d", k), m_res, m_status, m_rm, m_ctl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
Execute stage of the 5-stage ARM-subset pipeline, fed directly by the ID/EX pipeline register.
- Combinational part: operand forwarding muxes, Val2 generation (immediate rotate, register shift, memory offset), 32-bit ALU and branch target adder.
- Sequential part: the NZCV status register and the EXE/MEM pipeline register feeding the memory stage.

Parameters:
WIDTH, 32, datapath width; only 32 is supported.

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; one clock, synchronous, active-high
freeze  input  1  memory-stall hold; EXE/MEM register and status register keep their values
wb_en_in  input  1  write-back enable from ID/EX
mem_read_in  input  1  load
mem_write_in  input  1  store
imm_in  input  1  operand 2 is a rotated immediate
branch_in  input  1  branch, condition already resolved in ID
s_in  input  1  update status flags
exe_cmd_in  input  4  ALU command
dest_in  input  4  destination register index
shift_operand_in  input  12  shifter operand field
signed_imm_in  input  24  branch offset in words
pc_in  input  32  PC+4 of this instruction
val_rn_in  input  32  Rn value from register file
val_rm_in  input  32  Rm value from register file
sel_src1  input  2  Rn forward select: 00 val_rn_in, 01 mem_fwd_val, 10 wb_fwd_val, 11 val_rn_in
sel_src2  input  2  Rm forward select, same encoding
mem_fwd_val  input  32  ALU result currently in MEM stage
wb_fwd_val  input  32  write-back value
branch_taken  output  1  combinational, equals branch_in
branch_address  output  32  combinational branch target
status_out  output  4  registered {N,Z,C,V}, sent to ID condition check
wb_en_mem, mem_read_mem, mem_write_mem  output  1 each  registered controls
dest_mem  output  4  registered destination
alu_res_mem  output  32  registered ALU result / memory address
val_rm_mem  output  32  registered forwarded Rm (store data)

Behaviour:
- Reset: while rst is high at a rising edge, every registered output becomes 0 (status_out=4'b0000). rst has priority over freeze. Reset mid-stream discards the in-flight instruction.
- Operand selection: op1 and rm_f are chosen by sel_src1 and sel_src2; code 11 behaves as 00.
- Val2, checked in priority order:
  - mem_read_in or mem_write_in: sign-extend shift_operand_in[11:0].
  - imm_in: zero-extend shift_operand_in[7:0], rotate right by 2*shift_operand_in[11:8].
  - Otherwise: rm_f shifted by shift_operand_in[11:7] with type shift_operand_in[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR). An amount of 0 returns rm_f unchanged.
- ALU commands (cin = status_out C):
  - 0001 MOV = Val2; 1001 MVN = ~Val2
  - 0010 ADD = op1+Val2; 0011 ADC = op1+Val2+cin
  - 0100 SUB/CMP = op1−Val2; 0101 SBC = op1−Val2−!cin
  - 0110 AND/TST; 0111 ORR; 1000 EOR
  - Any other code gives result 0.
- Flags:
  - N = res[31]; Z = (res == 0).
  - Add-type ops: C = carry-out of bit 31; V = signed overflow.
  - Subtract-type ops: C = NOT borrow.
  - Logical ops and MOV/MVN leave C and V at their current values.
- Status register: loads {N,Z,C,V} on a rising edge when s_in=1, freeze=0 and rst=0; otherwise it holds. Gating on freeze keeps a re-presented ADC/SBC from seeing its own flags.
- Branch: branch_address = pc_in + (sign_extend(signed_imm_in) << 2), combinational and valid in the same cycle, with no latency. Wrap-around is modulo 2^32.
- EXE/MEM register: one-cycle latency. When freeze=0 it captures wb_en_in, mem_read_in, mem_write_in, dest_in, ALU result and rm_f. When freeze=1 it holds.
- Address path: loads and stores use ADD, so alu_res_mem = op1 + offset.

Decomposition:
- Shared package holds:
  - ALU command constants (MOV, MVN, ADD, ADC, SUB, SBC, AND, ORR, EOR).
  - Shift-type constants.
  - Forward-select encodings.
  - Status bit indices N=3, Z=2, C=1, V=0.
- One sub-module: val2_generator (purely combinational).
- The ALU, status register and EXE/MEM register stay inline.

Test Plan:
1. ADD immediate: Rn=5, imm_in=1, shift_operand=0x001, cmd 0010, s=1 -> after one edge alu_res_mem=6, status_out=0000.
2. SUB: Rn=3, Rm=3, register operand LSL #0, s=1 -> alu_res_mem=0, status_out=0110 (Z=1, C=1).
3. ADC with C=1: Rn=0xFFFFFFFF, Rm=0 -> result 0x00000000, status_out=0110. Then MOV with s=1, Val2=1 -> status_out=0010 (C kept).
4. Immediate rotate: imm8=0xFF, rotate=4, MOV, s=1 -> alu_res_mem=0xFF000000, N=1. Register ASR: Rm=0x80000000, shift #4 -> 0xF8000000.
5. Branch: pc_in=0x100, signed_imm=0xFFFFFE -> same cycle branch_address=0xF8, branch_taken=1. Forwarding: sel_src1=01, mem_fwd_val=7, ADD #1 -> alu_res_mem=8.
6. Freeze held 3 cycles with s=1 and a SUB giving Z -> outputs and status_out unchanged. Assert rst in cycle 2 -> all outputs 0 at the next edge despite freeze.
